ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

Parametrised PS/2 keyboard receiver that replaces the separate shift-register/counter/state-machine/decoder chain with a single frame-checked front end. It samples the raw `ps2_clk`/`ps2_data` lines on the system clock, validates each 11-bit frame (start, 8 data bits LSB first, odd parity, stop), folds `E0`/`F0` prefixes into flags, and buffers complete key events in a FIFO with a valid/ready output. It sits between the keyboard pins and the button recoder.

## Interface
- `FILTER_LEN`, 4: consecutive identical `ps2_clk` samples required before the filtered clock changes (≥2).
- `TIMEOUT`, 2500: `clk` cycles allowed between filtered falling edges inside a frame before it is aborted.
- `FIFO_DEPTH`, 8: key-event entries; power of two, ≥2.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ps2_clk` in 1: raw keyboard clock, asynchronous.
- `ps2_data` in 1: raw keyboard data, asynchronous.
- `key_valid` out 1: FIFO head holds an event.
- `key_ready` in 1: consumer accepts head when `key_valid`.
- `key_code` out 8: scan code of head entry.
- `key_break` out 1: head entry was preceded by `F0` (key release).
- `key_ext` out 1: head entry was preceded by `E0`.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: entries held, 0..FIFO_DEPTH.
- `frame_err` out 1: one-cycle pulse on bad start/parity/stop or timeout.
- `overflow` out 1: one-cycle pulse when a completed event is dropped because the FIFO is full.

## Operation
- Both inputs pass through 2-flop synchronisers (reset to 1). Filtered clock `fclk` resets to 1; it takes the synchronised value only after `FILTER_LEN` consecutive equal samples. A 1→0 transition of `fclk` produces a one-cycle strobe `fall`; all bit sampling uses synchronised `ps2_data` in the `fall` cycle.
- FSM states IDLE, DATA, PARITY, STOP:
  - IDLE: on `fall` with data=0 → DATA, bit count 0. On `fall` with data=1 → stay IDLE, no error.
  - DATA: on `fall` shift data into bit[count] (LSB first); after 8th bit → PARITY.
  - PARITY: on `fall` capture parity bit → STOP.
  - STOP: on `fall` → IDLE; frame good iff data=1 and data+parity has odd ones count, else `frame_err`.
  - Any non-IDLE state: timeout counter clears on each `fall`; reaching `TIMEOUT` → IDLE, `frame_err`, partial byte discarded.
- Good byte handling: `E0` sets ext flag, `F0` sets break flag, neither pushed. Any other byte pushes {ext, break, byte} and clears both flags. `frame_err` also clears both flags.
- FIFO is show-ahead: `key_code/key_break/key_ext` reflect head while `key_valid`; values are don't-care when empty. Pop when `key_valid && key_ready`.
- Full FIFO, push without pop: event dropped, `overflow` pulses, flags still cleared. Full with simultaneous push and pop: both succeed, count unchanged, no overflow. Empty with push: `key_ready` has no effect that cycle.
- Reset mid-frame: FSM to IDLE, flags cleared, FIFO emptied; remaining bits of the interrupted frame are treated as a new frame search (data=1 bits ignored in IDLE; a 0 bit starts a frame that will typically fail and pulse `frame_err`).

## Timing
- Reset values: `key_valid`=0, `key_code`=0, `key_break`=0, `key_ext`=0, `fifo_count`=0, `frame_err`=0, `overflow`=0.
- `fall` asserts `FILTER_LEN`+2 cycles after a raw `ps2_clk` falling edge (stable input).
- Stop-bit `fall` in cycle N → FIFO write and `frame_err`/`overflow` pulse at edge N+1 → `key_valid`=1 and `fifo_count` updated in cycle N+1.
- Pop at edge of cycle M: next head (or `key_valid`=0) visible in cycle M+1.
- Throughput: one event per cycle out; input limited by PS/2 rate.

## Structure
- Package `ps2_pkg`: FSM state enum, `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, packed struct `ps2_event_t` {ext, brk, code[7:0]}.
- Sub-module `ps2_sync_fifo` (parameters WIDTH, DEPTH; show-ahead, count output, simultaneous push/pop when full allowed). Synchroniser, filter, FSM and prefix logic live in `ps2_rx_fifo`.

## Test plan
- Frame 0x1C, parity 0, stop 1 → one entry, `key_code`=8'h1C, break=0, ext=0, `fifo_count`=1; pop with `key_ready` → `key_valid`=0.
- Frames F0, 1C → single entry 8'h1C break=1 ext=0; frames E0, F0, 75 → single entry 8'h75 break=1 ext=1.
- Frame 0x1C with parity 1 → `frame_err` pulse, FIFO unchanged; E0 then bad frame then 75 → entry 75 with ext=0.
- Start bit then 3 bits then silence `TIMEOUT` cycles → `frame_err` pulse, FSM IDLE; next good frame 0x1C accepted.
- `FIFO_DEPTH`+1 frames with `key_ready`=0 → count=`FIFO_DEPTH`, one `overflow` pulse, head still first code; full plus pop concurrent with push → count stays `FIFO_DEPTH`, no overflow.
- Glitch on `ps2_clk` shorter than `FILTER_LEN` cycles → no bit sampled; reset asserted mid-frame → all outputs 0, next full frame decoded correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 receiver shared types: FSM states, prefix codes,
// and the key-event bundle stored in the FIFO.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Odd parity over data plus parity bit.
  function automatic logic odd_ok(input logic [7:0] d,
                                  input logic       p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count;
// push is accepted when full if a pop happens in the same cycle.
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_pop;
  logic             do_push;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;
  assign count_o = cnt_q;

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: sync, clock filter, frame FSM,
// E0/F0 prefix folding and a key-event FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 2500,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [7:0]                    key_code,
  output logic                          key_break,
  output logic                          key_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_s_q;
  logic [1:0]    dat_s_q;
  logic          fclk_q;
  logic [FW-1:0] flt_q;
  logic          fall_q;
  logic          sd;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic          err_q, err_d;
  logic          ovf_q;
  logic          push;
  logic          pop;
  logic          full;
  ps2_event_t    wr_ev;
  ps2_event_t    head;

  assign sd = dat_s_q[1];

  // Two-flop synchronisers for the raw PS/2 lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s_q <= 2'b11;
      dat_s_q <= 2'b11;
    end else begin
      clk_s_q <= {clk_s_q[0], ps2_clk};
      dat_s_q <= {dat_s_q[0], ps2_data};
    end
  end

  // Clock filter: follow the line after FILTER_LEN equal samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fclk_q <= 1'b1;
      flt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clk_s_q[1] == fclk_q) begin
        flt_q <= '0;
      end else if (flt_q == FW'(FILTER_LEN - 1)) begin
        fclk_q <= clk_s_q[1];
        flt_q  <= '0;
        fall_q <= fclk_q;
      end else begin
        flt_q <= flt_q + 1'b1;
      end
    end
  end

  // Frame FSM next state, prefix flags and push decision.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    par_d   = par_q;
    tmo_d   = '0;
    ext_d   = ext_q;
    brk_d   = brk_q;
    err_d   = 1'b0;
    push    = 1'b0;
    if (state_q != ST_IDLE) begin
      tmo_d = fall_q ? '0 : tmo_q + 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (fall_q && !sd) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (fall_q) begin
          byte_d[bit_q] = sd;
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall_q) begin
          par_d   = sd;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall_q) begin
          state_d = ST_IDLE;
          if (sd && odd_ok(byte_q, par_q)) begin
            if (byte_q == PS2_EXT) begin
              ext_d = 1'b1;
            end else if (byte_q == PS2_BRK) begin
              brk_d = 1'b1;
            end else begin
              push  = 1'b1;
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && !fall_q &&
        tmo_q == TW'(TIMEOUT - 1)) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end
  end

  // Frame FSM and status pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      byte_q  <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      err_q   <= err_d;
      ovf_q   <= push && full && !pop;
    end
  end

  assign wr_ev = '{ext: ext_q, brk: brk_q, code: byte_q};
  assign pop   = key_valid && key_ready;

  ps2_sync_fifo #(
    .WIDTH ($bits(ps2_event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (wr_ev),
    .pop_i   (pop),
    .rdata_o (head),
    .valid_o (key_valid),
    .full_o  (full),
    .count_o (fifo_count)
  );

  assign key_code  = head.code;
  assign key_break = head.brk;
  assign key_ext   = head.ext;
  assign frame_err = err_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: frame-level reference queue checked
// every idle cycle plus directed literal expectations.
module tb_ps2_rx_fifo;

  localparam int FL    = 4;
  localparam int TO    = 200;
  localparam int DEPTH = 4;
  localparam int HALF  = 20;

  logic       clk = 0;
  logic       reset = 1;
  logic       ps2_clk = 1;
  logic       ps2_data = 1;
  logic       key_ready = 0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic [$clog2(DEPTH):0] fifo_count;
  logic       frame_err;
  logic       overflow;

  int checks = 0;
  int passed = 0;
  int err_seen = 0;
  int ovf_seen = 0;
  int exp_err = 0;
  int exp_ovf = 0;
  bit settled = 0;
  logic m_ext = 0;
  logic m_brk = 0;
  logic [9:0] mq[$];

  ps2_rx_fifo #(
    .FILTER_LEN (FL),
    .TIMEOUT    (TO),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_code   (key_code),
    .key_break  (key_break),
    .key_ext    (key_ext),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // Count status pulses seen on the outputs.
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_seen++;
    if (overflow === 1'b1) ovf_seen++;
  end

  // Compare outputs against the reference queue when the bus is quiet.
  always @(negedge clk) begin
    if (settled && !reset) begin
      checks++;
      if (key_valid === (mq.size() != 0) &&
          int'(fifo_count) == mq.size() &&
          (mq.size() == 0 ||
           {key_ext, key_break, key_code} === mq[0]) &&
          frame_err === 1'b0 && overflow === 1'b0)
        passed++;
      else if (checks - passed < 20)
        $display("FAIL cycle_cmp actual=v%b n%0d %b%b%h e%b o%b required=n%0d %h",
                 key_valid, fifo_count, key_ext, key_break, key_code,
                 frame_err, overflow, mq.size(),
                 (mq.size() != 0) ? mq[0] : 10'h0);
    end
  end

  task automatic ps2_bit(input logic b, input bit pop_here);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 0;
    if (pop_here) begin
      repeat (FL + 2) @(negedge clk);
      key_ready = 1;
      @(negedge clk);
      key_ready = 0;
      repeat (HALF - FL - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p,
                            input logic s, input bit pp);
    settled = 0;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
    ps2_bit(p, 0);
    ps2_bit(s, pp);
    ps2_data = 1;
    repeat (8) @(negedge clk);
    if (pp && mq.size() != 0) mq.delete(0);
    if (s && ($countones({b, p}) % 2 == 1)) begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, b});
        else exp_ovf++;
        m_ext = 0;
        m_brk = 0;
      end
    end else begin
      exp_err++;
      m_ext = 0;
      m_brk = 0;
    end
    settled = 1;
    chk("err_pulses", err_seen, exp_err);
    chk("ovf_pulses", ovf_seen, exp_ovf);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1, 0);
  endtask

  task automatic pop_one();
    settled = 0;
    @(negedge clk);
    key_ready = 1;
    @(negedge clk);
    key_ready = 0;
    if (mq.size() != 0) mq.delete(0);
    settled = 1;
  endtask

  task automatic chk_head(input string nm, input logic [7:0] c,
                          input logic brk, input logic ext);
    chk({nm, "_valid"}, int'(key_valid), 1);
    chk({nm, "_code"}, int'(key_code), int'(c));
    chk({nm, "_brk"}, int'(key_break), int'(brk));
    chk({nm, "_ext"}, int'(key_ext), int'(ext));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, int'(key_valid), 0);
    chk({nm, "_code"}, int'(key_code), 0);
    chk({nm, "_brk"}, int'(key_break), 0);
    chk({nm, "_ext"}, int'(key_ext), 0);
    chk({nm, "_count"}, int'(fifo_count), 0);
    chk({nm, "_ferr"}, int'(frame_err), 0);
    chk({nm, "_ovf"}, int'(overflow), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("rst");
    reset = 0;
    repeat (5) @(negedge clk);
    settled = 1;

    good(8'h1C);
    chk_head("plain", 8'h1C, 0, 0);
    chk("plain_count", int'(fifo_count), 1);
    pop_one();
    chk("plain_popped", int'(key_valid), 0);

    good(8'hF0);
    chk("brk_no_push", int'(fifo_count), 0);
    good(8'h1C);
    chk_head("brk", 8'h1C, 1, 0);
    pop_one();
    good(8'hE0);
    good(8'hF0);
    good(8'h75);
    chk_head("extbrk", 8'h75, 1, 1);
    chk("extbrk_count", int'(fifo_count), 1);
    pop_one();

    send_frame(8'h1C, 1'b1, 1'b1, 0);
    chk("bad_par_count", int'(fifo_count), 0);
    chk("bad_par_err", err_seen, 1);
    good(8'hE0);
    send_frame(8'h1C, 1'b0, 1'b0, 0);
    good(8'h75);
    chk_head("err_clr", 8'h75, 0, 0);
    pop_one();

    settled = 0;
    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    repeat (TO + 20) @(negedge clk);
    exp_err++;
    m_ext = 0;
    m_brk = 0;
    settled = 1;
    chk("timeout_err", err_seen, 3);
    good(8'h1C);
    chk_head("after_to", 8'h1C, 0, 0);
    pop_one();

    good(8'h11);
    good(8'h22);
    good(8'h33);
    good(8'h44);
    good(8'h55);
    chk("full_count", int'(fifo_count), DEPTH);
    chk("full_ovf", ovf_seen, 1);
    chk_head("full", 8'h11, 0, 0);
    send_frame(8'h66, ~^8'h66, 1'b1, 1);
    chk("pp_count", int'(fifo_count), DEPTH);
    chk("pp_ovf", ovf_seen, 1);
    chk_head("pp", 8'h22, 0, 0);
    for (int i = 0; i < DEPTH; i++) pop_one();
    chk("drained", int'(key_valid), 0);

    ps2_data = 0;
    @(negedge clk);
    ps2_clk = 0;
    repeat (FL - 1) @(negedge clk);
    ps2_clk = 1;
    repeat (TO + 20) @(negedge clk);
    ps2_data = 1;
    repeat (4) @(negedge clk);
    chk("glitch_err", err_seen, 3);
    good(8'h1C);
    chk_head("after_glitch", 8'h1C, 0, 0);
    pop_one();

    good(8'h33);
    good(8'hE0);
    settled = 0;
    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    ps2_bit(1'b1, 0);
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    chk_zero("midrst");
    reset = 0;
    mq.delete();
    m_ext = 0;
    m_brk = 0;
    repeat (10) @(negedge clk);
    settled = 1;
    good(8'h75);
    chk_head("after_rst", 8'h75, 0, 0);
    chk("after_rst_count", int'(fifo_count), 1);
    pop_one();
    repeat (5) @(negedge clk);
    settled = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
